mf_clken_gen: RTL and testbench

- Parametrised, run-time programmable clock-enable generator. Successor to the fixed five-output PLL wrapper.
- Derives NUM_CH independent fractional-rate clock enables from one master clock using phase accumulators (NCOs). Each channel also provides a 180°-offset enable.
- Gates all enables on a debounced PLL lock.
- Sits between the core PLL and the game/video/audio logic. Replaces extra PLL outputs with enables on a single clock domain.

---
 rtl/mf_clken_pkg.sv | 19 +
 rtl/mf_clken_if.sv | 27 ++
 rtl/mf_clken_nco.sv | 57 +++++
 rtl/mf_clken_gen.sv | 110 +++++++++++
 tb/tb_mf_clken_gen.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mf_clken_pkg.sv
// Shared types and helpers for the clock-enable generator.
package mf_clken_pkg;

    // Lock/run sequencing states.
    typedef enum logic [1:0] {
        StWaitLock,
        StStabilize,
        StAlign,
        StRun
    } state_e;

    localparam int unsigned DefaultAccW = 32;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mf_clken_if.sv
// Configuration write bus: channel increment/phase writes and realign pulse.
interface mf_clken_if
    import mf_clken_pkg::*;
#(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned ACC_W  = DefaultAccW
);
    localparam int unsigned ChW = ch_idx_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [ChW-1:0]   cfg_ch;
    logic [ACC_W-1:0] cfg_inc;
    logic [ACC_W-1:0] cfg_phase;
    logic             cfg_apply;

    modport master (
        output cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_apply,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_inc, cfg_phase, cfg_apply,
        output cfg_ready
    );

endinterface

// File: rtl/mf_clken_nco.sv
// One phase-accumulator channel: programmable increment and start phase,
// producing a carry pulse and a half-period-offset carry pulse.
module mf_clken_nco
    import mf_clken_pkg::*;
#(
    parameter int unsigned ACC_W = DefaultAccW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic [ACC_W-1:0] phase_i,
    input  logic             load_i,
    input  logic             run_i,
    output logic             ce_o,
    output logic             ce_mid_o
);

    localparam logic [ACC_W-1:0] HalfTurn = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] inc_q, phase_q, acc_q;
    logic             ce_q, ce_mid_q;
    logic [ACC_W:0]   sum, sum_mid;

    // Next accumulator value and the carries of the direct and half-turn-shifted phases.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, inc_q};
        sum_mid = {1'b0, acc_q ^ HalfTurn} + {1'b0, inc_q};
    end

    // Shadow registers, accumulator and registered enables.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inc_q    <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
            ce_q     <= 1'b0;
            ce_mid_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                inc_q   <= inc_i;
                phase_q <= phase_i;
            end
            if (load_i) begin
                acc_q <= phase_q;
            end else if (run_i) begin
                acc_q <= sum[ACC_W-1:0];
            end
            ce_q     <= run_i & sum[ACC_W];
            ce_mid_q <= run_i & sum_mid[ACC_W];
        end
    end

    assign ce_o     = ce_q;
    assign ce_mid_o = ce_mid_q;

endmodule

// File: rtl/mf_clken_gen.sv
// Programmable multi-channel clock-enable generator gated on a debounced PLL lock.
module mf_clken_gen
    import mf_clken_pkg::*;
#(
    parameter int unsigned NUM_CH             = 5,
    parameter int unsigned ACC_W              = DefaultAccW,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned UNLOCK_CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    mf_clken_if.slave               cfg,
    output logic [NUM_CH-1:0]       ce,
    output logic [NUM_CH-1:0]       ce_mid,
    output logic                    ready,
    output logic [UNLOCK_CNT_W-1:0] unlock_cnt
);

    localparam int unsigned      ChW      = ch_idx_w(NUM_CH);
    localparam int unsigned      StabW    = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_s;
    state_e                  state_q, state_d;
    logic [StabW-1:0]        stab_q, stab_d;
    logic [UNLOCK_CNT_W-1:0] unlock_q, unlock_d;
    logic                    lost, load, run, wr_en;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Lock sequencing, stability count and saturating loss-of-lock count.
    always_comb begin
        state_d  = state_q;
        stab_d   = stab_q;
        unlock_d = unlock_q;
        lost     = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            StWaitLock: begin
                stab_d = '0;
                if (lock_s) state_d = StStabilize;
            end
            StStabilize: begin
                stab_d = stab_q + 1'b1;
                if (!lock_s) begin
                    state_d = StWaitLock;
                    lost    = 1'b1;
                end else if (stab_q == StabLast) begin
                    state_d = StAlign;
                end
            end
            StAlign: begin
                load    = 1'b1;
                state_d = lock_s ? StRun : StWaitLock;
            end
            StRun: begin
                if (!lock_s) begin
                    state_d = StWaitLock;
                    lost    = 1'b1;
                end else if (cfg.cfg_apply) begin
                    state_d = StAlign;
                end
            end
            default: state_d = StWaitLock;
        endcase
        if (lost && (unlock_q != {UNLOCK_CNT_W{1'b1}})) unlock_d = unlock_q + 1'b1;
    end

    // Lock synchroniser and FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state_q  <= StWaitLock;
            stab_q   <= '0;
            unlock_q <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q  <= state_d;
            stab_q   <= stab_d;
            unlock_q <= unlock_d;
        end
    end

    // Advance only while staying in RUN so enables drop on the edge that leaves it.
    assign run           = (state_q == StRun) && (state_d == StRun);
    assign cfg.cfg_ready = (state_q != StAlign);
    assign wr_en         = cfg.cfg_valid && cfg.cfg_ready;
    assign ready         = (state_q == StRun);
    assign unlock_cnt    = unlock_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        mf_clken_nco #(
            .ACC_W (ACC_W)
        ) u_nco (
            .clk_i    (clk),
            .rst_ni   (reset_n),
            .wr_en_i  (wr_en && (cfg.cfg_ch == ChW'(i))),
            .inc_i    (cfg.cfg_inc),
            .phase_i  (cfg.cfg_phase),
            .load_i   (load),
            .run_i    (run),
            .ce_o     (ce[i]),
            .ce_mid_o (ce_mid[i])
        );
    end

endmodule

// File: tb/tb_mf_clken_gen.sv
// Directed bench for mf_clken_gen: table-driven NCO vectors plus lock/reset sequences.
module tb_mf_clken_gen;
    import mf_clken_pkg::*;

    localparam int unsigned NCH = 5;
    localparam int unsigned AW  = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           pll_locked;
    logic [NCH-1:0] ce, ce_mid;
    logic           ready;
    logic [1:0]     unlock_cnt;

    mf_clken_if #(.NUM_CH(NCH), .ACC_W(AW)) cfg_bus ();

    mf_clken_gen #(
        .NUM_CH             (NCH),
        .ACC_W              (AW),
        .LOCK_STABLE_CYCLES (16),
        .SYNC_STAGES        (2),
        .UNLOCK_CNT_W       (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_locked (pll_locked),
        .cfg        (cfg_bus.slave),
        .ce         (ce),
        .ce_mid     (ce_mid),
        .ready      (ready),
        .unlock_cnt (unlock_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] inc;
        logic [31:0] phase;
        int          n;
        int          exp_ce;
        int          exp_mid;
        int          first_ce;
        int          first_mid;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write happens at the following posedge.
    task automatic cfg_write(input logic [2:0] ch, input logic [31:0] inc,
                             input logic [31:0] ph, input logic apply);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = ch;
        cfg_bus.cfg_inc   = inc;
        cfg_bus.cfg_phase = ph;
        cfg_bus.cfg_apply = apply;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_apply = 1'b0;
    endtask

    // Counts negedges until ready; lock raised at a negedge gives 2 sync + 1 FSM
    // reaction + 16 STABILIZE + 1 ALIGN = 20 edges.
    task automatic wait_ready(input string name, input int exp_n);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, n, exp_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_ce, cnt_mid, f_ce, f_mid, last, bad_gaps, silent, c0, m0;

        //                inc           phase         n   ce  mid fce fmid
        vecs[0] = '{32'h4000_0000, 32'h0000_0000, 12,  3,  3, 4, 2};
        vecs[1] = '{32'h4000_0000, 32'h8000_0000, 12,  3,  3, 2, 4};
        vecs[2] = '{32'h5555_5555, 32'h0000_0000, 30,  9, 10, 4, 2};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 30,  0,  0, 0, 0};
        vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 12, 11, 12, 2, 1};
        vecs[5] = '{32'h8000_0000, 32'h4000_0000,  8,  4,  4, 2, 1};
        vecs[6] = '{32'h0000_0001, 32'hFFFF_FFFE,  5,  1,  0, 2, 0};

        reset_n           = 1'b0;
        pll_locked        = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_inc   = '0;
        cfg_bus.cfg_phase = '0;
        cfg_bus.cfg_apply = 1'b0;
        cycles(3);
        check("rst_ce", ce, 0);
        check("rst_ce_mid", ce_mid, 0);
        check("rst_ready", ready, 0);
        check("rst_unlock_cnt", unlock_cnt, 0);
        check("rst_cfg_ready", cfg_bus.cfg_ready, 1);
        reset_n = 1'b1;
        cycles(2);
        check("nolock_ready", ready, 0);

        // Lock sequence: ch0 at quarter rate, phase 0.
        cfg_write(0, 32'h4000_0000, 32'h0, 1'b0);
        pll_locked = 1'b1;
        wait_ready("lock_latency", 20);
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            check("lock_ce0", ce[0], ((j % 4) == 0));
            check("lock_ce_mid0", ce_mid[0], ((j % 4) == 2));
        end

        // Table: write ch0 together with cfg_apply, then count pulses after ALIGN.
        for (int v = 0; v < 7; v++) begin
            cnt_ce = 0; cnt_mid = 0; f_ce = 0; f_mid = 0;
            cfg_write(0, vecs[v].inc, vecs[v].phase, 1'b1);
            check("align_cfg_ready", cfg_bus.cfg_ready, 0);
            check("align_ce", ce, 0);
            @(negedge clk);
            for (int k = 1; k <= vecs[v].n; k++) begin
                @(negedge clk);
                if (ce[0]) begin
                    cnt_ce++;
                    if (f_ce == 0) f_ce = k;
                end
                if (ce_mid[0]) begin
                    cnt_mid++;
                    if (f_mid == 0) f_mid = k;
                end
            end
            check("vec_ce_count", cnt_ce, vecs[v].exp_ce);
            check("vec_mid_count", cnt_mid, vecs[v].exp_mid);
            check("vec_first_ce", f_ce, vecs[v].first_ce);
            check("vec_first_mid", f_mid, vecs[v].first_mid);
        end

        // Fractional rate on ch2: pulses at edges 4,7,...,2998 -> 999, gaps of 3 or 4.
        cfg_write(2, 32'h5555_5555, 32'h0, 1'b1);
        @(negedge clk);
        cnt_ce = 0; last = 0; bad_gaps = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (ce[2]) begin
                if (last != 0 && (k - last < 3 || k - last > 4)) bad_gaps++;
                last = k;
                cnt_ce++;
            end
        end
        check("frac_count", cnt_ce, 999);
        check("frac_bad_gaps", bad_gaps, 0);

        // Out-of-range channel write is dropped; ch1/3/4 stay at inc=0 for 1000 cycles.
        // ch0 (inc 1, phase FFFF_FFFE) realigns and carries once; its mid never carries.
        cfg_write(5, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        @(negedge clk);
        silent = 0; c0 = 0; m0 = 0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if ((ce & 5'b11010) != 0 || (ce_mid & 5'b11010) != 0) silent++;
            if (ce[0]) c0++;
            if (ce_mid[0]) m0++;
        end
        check("idle_channels_silent", silent, 0);
        check("bad_ch_ce0_count", c0, 1);
        check("bad_ch_mid0_count", m0, 0);

        // Lock loss in RUN: ch0 at max rate so its enables are high just before the drop.
        cfg_write(0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        cycles(3);
        pll_locked = 1'b0;
        cycles(2);
        check("loss_ready_still", ready, 1);
        check("loss_ce0_still", ce[0], 1);
        check("loss_mid0_still", ce_mid[0], 1);
        cycles(1);
        check("loss_ready", ready, 0);
        check("loss_ce", ce, 0);
        check("loss_ce_mid", ce_mid, 0);
        check("loss_unlock_cnt", unlock_cnt, 1);
        cycles(2);
        pll_locked = 1'b1;
        wait_ready("relock_latency", 20);

        // Four more losses (first from RUN, rest from STABILIZE): counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            pll_locked = 1'b0;
            cycles(5);
            check("sat_unlock_cnt", unlock_cnt, (i + 2 > 3) ? 3 : i + 2);
            pll_locked = 1'b1;
            if (i < 3) cycles(8);
        end
        wait_ready("relock_after_losses", 20);
        check("sat_final", unlock_cnt, 3);

        // Async reset between edges while running at max rate.
        cycles(3);
        check("pre_reset_ce0", ce[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ce", ce, 0);
        check("async_rst_ce_mid", ce_mid, 0);
        check("async_rst_ready", ready, 0);
        check("async_rst_unlock", unlock_cnt, 0);
        check("async_rst_cfg_ready", cfg_bus.cfg_ready, 1);
        check("async_rst_state", dut.state_q, StWaitLock);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready("post_reset_relock", 20);
        silent = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ce != 0 || ce_mid != 0) silent++;
        end
        check("post_reset_inc_cleared", silent, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
